ddr_write_packer: RTL

- ADC-side capture packer, in the rd_clk (ADC/DAC master) domain. It feeds the write port of the DDR write FIFO, the opposite direction to the DDR read path.
- Accepts 32-bit ADC samples and packs 4 samples into one 128-bit AXI-width word, then writes that word into the asynchronous DDR write FIFO.
- Frames a capture as either a fixed sample count or continuous, pads the final partial word, and reports overflow when the FIFO cannot accept a word.

---
 rtl/ddr_write_packer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ddr_write_packer.sv
// ddr_write_packer
//   Packs 32-bit ADC samples into 128-bit words (lane 0 = first sample,
//   bits [31:0]) and writes them into the DDR write FIFO. A capture is either
//   a fixed sample count (capture_len != 0) or continuous (capture_len == 0,
//   ends when ctrl_wr_en drops). The final partial word is padded with
//   PAD_VALUE. A word that completes while fifo_full is high is dropped and
//   counted, because the ADC cannot be stalled.
// Ports
//   rd_clk, rst      clock, synchronous active-high reset
//   ctrl_wr_en       capture enable level
//   capture_len      samples per capture, latched at start, 0 = continuous
//   sample_in/valid  ADC sample stream, no backpressure
//   fifo_din/wr_en   write side of the DDR write FIFO (1-cycle pulse per word)
//   fifo_full        FIFO full, sampled on the cycle a word completes
//   busy, done       registered state flags (CAPTURE/FLUSH, DONE)
//   overflow         sticky: a word was dropped in this capture
//   drop_count       dropped words, saturating
//   word_count       words written in this capture
module ddr_write_packer #(
    parameter int              IN_W      = 32,
    parameter int              OUT_W     = 128,
    parameter logic [IN_W-1:0] PAD_VALUE = '0,
    parameter int              DROP_W    = 16
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              ctrl_wr_en,
    input  logic [31:0]       capture_len,
    input  logic [IN_W-1:0]   sample_in,
    input  logic              sample_valid,
    output logic [OUT_W-1:0]  fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic [31:0]       word_count
);

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

    state_t                 state, state_next;
    logic [31:0]            len_q;
    logic [31:0]            samp_cnt;
    logic [1:0]             lane_cnt;
    logic [2:0][IN_W-1:0]   lane_buf;   // lanes 0..2; lane 3 comes straight from sample_in
    logic                   accept;
    logic                   last_sample;
    logic                   word_rdy;
    logic [OUT_W-1:0]       full_word;
    logic [OUT_W-1:0]       pad_word;
    logic [OUT_W-1:0]       word_val;

    always_comb begin
        accept      = (state == CAPTURE) && sample_valid;
        last_sample = accept && (len_q != 32'd0) && (samp_cnt + 32'd1 == len_q);
        state_next  = state;
        case (state)
            IDLE:    if (ctrl_wr_en) state_next = CAPTURE;
            CAPTURE: if (last_sample || !ctrl_wr_en) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    if (!ctrl_wr_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word assembly: the lane-3 sample completes a word on the cycle it arrives;
    // in FLUSH the lanes not yet filled take PAD_VALUE (lane 3 is never filled).
    always_comb begin
        full_word = {sample_in, lane_buf[2], lane_buf[1], lane_buf[0]};
        pad_word  = {OUT_W{1'b0}};
        for (int k = 0; k < 3; k++)
            pad_word[IN_W*k +: IN_W] = (2'(k) < lane_cnt) ? lane_buf[k] : PAD_VALUE;
        pad_word[IN_W*3 +: IN_W] = PAD_VALUE;
        word_rdy = (accept && lane_cnt == 2'd3) || (state == FLUSH && lane_cnt != 2'd0);
        word_val = (state == FLUSH) ? pad_word : full_word;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            len_q      <= 32'd0;
            samp_cnt   <= 32'd0;
            lane_cnt   <= 2'd0;
            lane_buf   <= '0;
            fifo_din   <= '0;
            fifo_wr_en <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            word_count <= 32'd0;
        end else begin
            state      <= state_next;
            busy       <= (state_next == CAPTURE) || (state_next == FLUSH);
            done       <= (state_next == DONE);
            fifo_wr_en <= 1'b0;

            if (state == IDLE && ctrl_wr_en) begin
                len_q      <= capture_len;
                samp_cnt   <= 32'd0;
                lane_cnt   <= 2'd0;
                word_count <= 32'd0;
                drop_count <= '0;
                overflow   <= 1'b0;
            end

            if (accept) begin
                case (lane_cnt)
                    2'd0:    lane_buf[0] <= sample_in;
                    2'd1:    lane_buf[1] <= sample_in;
                    2'd2:    lane_buf[2] <= sample_in;
                    default: ;
                endcase
                samp_cnt <= samp_cnt + 32'd1;   // wraps harmlessly in continuous mode
                lane_cnt <= lane_cnt + 2'd1;
            end

            if (state == FLUSH)
                lane_cnt <= 2'd0;

            if (word_rdy) begin
                if (!fifo_full) begin
                    fifo_din   <= word_val;
                    fifo_wr_en <= 1'b1;
                    word_count <= word_count + 32'd1;
                end else begin
                    overflow <= 1'b1;
                    if (drop_count != {DROP_W{1'b1}})
                        drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule
